// File: rtl/sha_host_pkg.sv
// Shared types and protocol constants for the SHA nonce-search host initiator.
package sha_host_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SEND_HELLO,
        WAIT_HELLO,
        SEND_PAYLOAD,
        WAIT_START,
        WAIT_RESULT,
        RECV_NONCE,
        SEND_RESET,
        WAIT_RESET,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_TIMEOUT    = 3'd1,
        ERR_REMOTE     = 3'd2,
        ERR_UNEXPECTED = 3'd3,
        ERR_ABORTED    = 3'd4
    } err_e;

    localparam int PAYLOAD_BYTES = 84;

    localparam logic [7:0] CMD_HELLO    = 8'h48;  // 'H'
    localparam logic [7:0] CMD_RESET    = 8'h52;  // 'R'
    localparam logic [7:0] RSP_HELLO    = 8'h31;  // '1'
    localparam logic [7:0] RSP_RESET    = 8'h4F;  // 'O'
    localparam logic [7:0] RSP_START    = 8'h53;  // 'S'
    localparam logic [7:0] RSP_FOUND    = 8'h59;  // 'Y'
    localparam logic [7:0] RSP_NOTFOUND = 8'h4E;  // 'N'
    localparam logic [7:0] RSP_ERR      = 8'h45;  // 'E'
    localparam logic [7:0] RSP_ERR_ALT  = 8'h65;  // 'e'

    function automatic logic is_err_byte(input logic [7:0] b);
        return (b == RSP_ERR) || (b == RSP_ERR_ALT);
    endfunction

endpackage

// File: rtl/sha_job_host_if.sv
// Job, UART byte-stream and result signals between the host initiator and its environment.
interface sha_job_host_if;
    import sha_host_pkg::*;

    logic                               job_valid;
    logic                               job_ready;
    logic [PAYLOAD_BYTES-1:0][7:0]      job_payload;
    logic                               abort;
    logic [7:0]                         tx_data;
    logic                               tx_valid;
    logic                               tx_ready;
    logic [7:0]                         rx_data;
    logic                               rx_valid;
    logic                               res_valid;
    logic                               res_found;
    logic [31:0]                        res_nonce;
    logic [2:0]                         res_err;
    logic                               busy;

    modport master (
        input  job_valid, job_payload, abort, tx_ready, rx_data, rx_valid,
        output job_ready, tx_data, tx_valid, res_valid, res_found, res_nonce, res_err, busy
    );

    modport slave (
        output job_valid, job_payload, abort, tx_ready, rx_data, rx_valid,
        input  job_ready, tx_data, tx_valid, res_valid, res_found, res_nonce, res_err, busy
    );

endinterface

// File: rtl/sha_host_timer.sv
// Reply watchdog: reloads while idle, counts down while enabled; RESP_TIMEOUT of 0 never expires.
module sha_host_timer #(
    parameter int unsigned RESP_TIMEOUT = 10_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [31:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= 32'(RESP_TIMEOUT);
        end else if (load) begin
            count <= 32'(RESP_TIMEOUT);
        end else if (en && count != 32'd0) begin
            count <= count - 32'd1;
        end
    end

    assign expired = (RESP_TIMEOUT != 0) && en && (count == 32'd0);

endmodule

// File: rtl/sha_job_host.sv
// Host-side job sequencer: sends hello and payload, collects start/result replies, recovers with R/O.
module sha_job_host
    import sha_host_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT = 10_000_000
) (
    input logic            clk,
    input logic            rstn,
    sha_job_host_if.master bus
);

    localparam logic [6:0] LAST_IDX = 7'(PAYLOAD_BYTES - 1);

    state_e                        state;
    err_e                          err_code;
    logic [PAYLOAD_BYTES-1:0][7:0] payload;
    logic [6:0]                    pay_idx;
    logic [1:0]                    nonce_idx;
    logic [23:0]                   nonce_low;
    logic                          timed;
    logic                          expired;
    logic                          tx_done;

    assign bus.job_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign timed         = state inside {WAIT_HELLO, WAIT_START, WAIT_RESET};
    assign tx_done       = bus.tx_valid && bus.tx_ready;

    // The counter reloads whenever the FSM is outside a timed wait, so every entry starts fresh.
    sha_host_timer #(.RESP_TIMEOUT(RESP_TIMEOUT)) timer (
        .clk     (clk),
        .rstn    (rstn),
        .load    (~timed),
        .en      (timed),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (bus.job_valid && bus.job_ready) begin
            payload <= bus.job_payload;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            err_code      <= ERR_NONE;
            pay_idx       <= '0;
            nonce_idx     <= '0;
            nonce_low     <= '0;
            bus.tx_valid  <= 1'b0;
            bus.tx_data   <= '0;
            bus.res_valid <= 1'b0;
            bus.res_found <= 1'b0;
            bus.res_nonce <= '0;
            bus.res_err   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.job_valid) begin
                        state        <= SEND_HELLO;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= CMD_HELLO;
                        err_code     <= ERR_NONE;
                    end
                end
                // An abort while a byte is offered is remembered in err_code until that byte goes out.
                SEND_HELLO, SEND_PAYLOAD: begin
                    if (bus.abort) err_code <= ERR_ABORTED;
                    if (tx_done) begin
                        if (bus.abort || err_code != ERR_NONE) begin
                            state       <= SEND_RESET;
                            bus.tx_data <= CMD_RESET;
                        end else if (state == SEND_HELLO) begin
                            state        <= WAIT_HELLO;
                            bus.tx_valid <= 1'b0;
                        end else if (pay_idx == LAST_IDX) begin
                            state        <= WAIT_START;
                            bus.tx_valid <= 1'b0;
                        end else begin
                            pay_idx     <= pay_idx + 7'd1;
                            bus.tx_data <= payload[pay_idx + 7'd1];
                        end
                    end
                end
                WAIT_HELLO, WAIT_START, WAIT_RESULT: begin
                    if (bus.abort) begin
                        state        <= SEND_RESET;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= CMD_RESET;
                        err_code     <= ERR_ABORTED;
                    end else if (bus.rx_valid) begin
                        if (state == WAIT_HELLO && bus.rx_data == RSP_HELLO) begin
                            state        <= SEND_PAYLOAD;
                            bus.tx_valid <= 1'b1;
                            bus.tx_data  <= payload[0];
                            pay_idx      <= '0;
                        end else if (state == WAIT_START && bus.rx_data == RSP_START) begin
                            state <= WAIT_RESULT;
                        end else if (state == WAIT_RESULT && bus.rx_data == RSP_FOUND) begin
                            state     <= RECV_NONCE;
                            nonce_idx <= '0;
                        end else if (state == WAIT_RESULT && bus.rx_data == RSP_NOTFOUND) begin
                            state         <= DONE;
                            bus.res_valid <= 1'b1;
                            bus.res_found <= 1'b0;
                            bus.res_nonce <= '0;
                            bus.res_err   <= ERR_NONE;
                        end else begin
                            state        <= SEND_RESET;
                            bus.tx_valid <= 1'b1;
                            bus.tx_data  <= CMD_RESET;
                            err_code     <= is_err_byte(bus.rx_data) ? ERR_REMOTE : ERR_UNEXPECTED;
                        end
                    end else if (expired) begin
                        state        <= SEND_RESET;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= CMD_RESET;
                        err_code     <= ERR_TIMEOUT;
                    end
                end
                // Nonce arrives LSB first; the low three bytes shift down, the fourth completes the word.
                RECV_NONCE: begin
                    if (bus.abort) begin
                        state        <= SEND_RESET;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= CMD_RESET;
                        err_code     <= ERR_ABORTED;
                    end else if (bus.rx_valid) begin
                        nonce_idx <= nonce_idx + 2'd1;
                        nonce_low <= {bus.rx_data, nonce_low[23:8]};
                        if (nonce_idx == 2'd3) begin
                            state         <= DONE;
                            bus.res_valid <= 1'b1;
                            bus.res_found <= 1'b1;
                            bus.res_nonce <= {bus.rx_data, nonce_low};
                            bus.res_err   <= ERR_NONE;
                        end
                    end
                end
                SEND_RESET: begin
                    if (tx_done) begin
                        state        <= WAIT_RESET;
                        bus.tx_valid <= 1'b0;
                    end
                end
                WAIT_RESET: begin
                    if ((bus.rx_valid && bus.rx_data == RSP_RESET) || (!bus.rx_valid && expired)) begin
                        state         <= DONE;
                        bus.res_valid <= 1'b1;
                        bus.res_found <= 1'b0;
                        bus.res_nonce <= '0;
                        bus.res_err   <= err_code;
                    end
                end
                DONE: begin
                    bus.res_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_job_host.sv
// Scoreboard bench for sha_job_host: stimulus pushes expected TX bytes and results, a monitor pops and compares.
module tb_sha_job_host;

    typedef struct packed {
        logic        found;
        logic [31:0] nonce;
        logic [2:0]  err;
    } res_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sha_job_host_if bus();

    sha_job_host #(.RESP_TIMEOUT(100)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int   errors    = 0;
    int   checks    = 0;
    int   tx_count  = 0;
    int   res_count = 0;
    logic [7:0] tx_q[$];
    res_t       res_q[$];
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic [83:0][7:0] pl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: samples mid-cycle, so a valid&&ready seen here transfers at the next rising edge.
    logic [7:0] exp_b;
    res_t       exp_r;
    always @(negedge clk) begin
        if (!rstn) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("tx_hold_valid", bus.tx_valid, 1);
                check("tx_hold_data", bus.tx_data, hold_data);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                tx_count++;
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got byte %02h, required none", bus.tx_data);
                end else begin
                    exp_b = tx_q.pop_front();
                    check("tx_byte", bus.tx_data, exp_b);
                end
            end
            hold_pend = bus.tx_valid && !bus.tx_ready;
            hold_data = bus.tx_data;
            if (bus.res_valid) begin
                res_count++;
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_unexpected: got err %0d, required no result", bus.res_err);
                end else begin
                    exp_r = res_q.pop_front();
                    check("res_found", bus.res_found, exp_r.found);
                    check("res_nonce", bus.res_nonce, exp_r.nonce);
                    check("res_err", bus.res_err, exp_r.err);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_tx(input int target, input string name);
        int n = 0;
        while (tx_count < target && n < 3000) begin
            step();
            n++;
        end
        check({name, "_reached"}, (tx_count >= target), 1);
    endtask

    task automatic send_rx(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        step();
        bus.rx_valid = 1'b0;
    endtask

    task automatic push_payload(input int n);
        for (int i = 0; i < n; i++) tx_q.push_back(pl[i]);
    endtask

    task automatic start_job();
        int n = 0;
        while (!bus.job_ready && n < 100) begin
            step();
            n++;
        end
        bus.job_payload = pl;
        bus.job_valid   = 1'b1;
        tx_q.push_back(8'h48);
        step();
        bus.job_valid = 1'b0;
        check("hello_latency", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h48});
    endtask

    task automatic finish_check(input string name);
        check({name, "_res_valid"}, bus.res_valid, 1);
        check({name, "_not_ready"}, bus.job_ready, 0);
        step();
        check({name, "_ready"}, bus.job_ready, 1);
        check({name, "_pulse"}, bus.res_valid, 0);
    endtask

    task automatic run_notfound(input string name);
        int base = tx_count;
        start_job();
        wait_tx(base + 1, {name, "_hello"});
        push_payload(84);
        send_rx(8'h31);
        wait_tx(base + 85, {name, "_payload"});
        send_rx(8'h53);
        res_q.push_back('{1'b0, 32'h0, 3'd0});
        send_rx(8'h4E);
        finish_check(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        bus.job_valid   = 1'b0;
        bus.job_payload = '0;
        bus.abort       = 1'b0;
        bus.tx_ready    = 1'b1;
        bus.rx_data     = 8'h00;
        bus.rx_valid    = 1'b0;
        for (int i = 0; i < 84; i++) pl[i] = 8'h80 + 8'(i);

        #12;
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_found", bus.res_found, 0);
        check("rst_res_nonce", bus.res_nonce, 0);
        check("rst_res_err", bus.res_err, 0);
        check("rst_job_ready", bus.job_ready, 1);
        check("rst_busy", bus.busy, 0);
        step();
        rstn = 1'b1;
        step();

        // Found job with a 10-cycle stall while payload byte 5 is offered.
        base = tx_count;
        start_job();
        check("busy_in_job", bus.busy, 1);
        wait_tx(base + 1, "found_hello");
        push_payload(84);
        send_rx(8'h31);
        check("payload_latency", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h80});
        wait_tx(base + 6, "bp_pre");
        bus.tx_ready = 1'b0;
        repeat (10) step();
        check("bp_data", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h85});
        bus.tx_ready = 1'b1;
        wait_tx(base + 85, "found_payload");
        check("tx_total", tx_count - base, 85);
        check("wait_start_idle_tx", bus.tx_valid, 0);
        send_rx(8'h53);
        send_rx(8'h59);
        send_rx(8'h78);
        send_rx(8'h56);
        send_rx(8'h34);
        res_q.push_back('{1'b1, 32'h1234_5678, 3'd0});
        send_rx(8'h12);
        finish_check("found");
        repeat (3) step();
        check("hold_found", bus.res_found, 1);
        check("hold_nonce", bus.res_nonce, 32'h1234_5678);

        run_notfound("notfound");

        // Silence after 'H': the watchdog forces the reset exchange.
        base = tx_count;
        start_job();
        wait_tx(base + 1, "to_hello");
        tx_q.push_back(8'h52);
        n = 0;
        while (tx_count < base + 2 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (!(n >= 95 && n <= 110)) begin
            errors++;
            $display("FAIL timeout_delay: got %0d cycles, required 95..110", n);
        end
        send_rx(8'h58);
        step();
        res_q.push_back('{1'b0, 32'h0, 3'd1});
        send_rx(8'h4F);
        finish_check("timeout");

        // Remote error reply to hello.
        base = tx_count;
        start_job();
        wait_tx(base + 1, "err_hello");
        tx_q.push_back(8'h52);
        send_rx(8'h45);
        wait_tx(base + 2, "err_reset");
        res_q.push_back('{1'b0, 32'h0, 3'd2});
        send_rx(8'h4F);
        finish_check("remote_err");

        // Unexpected byte while waiting for start.
        base = tx_count;
        start_job();
        wait_tx(base + 1, "unexp_hello");
        push_payload(84);
        send_rx(8'h31);
        wait_tx(base + 85, "unexp_payload");
        tx_q.push_back(8'h52);
        send_rx(8'h5A);
        wait_tx(base + 86, "unexp_reset");
        res_q.push_back('{1'b0, 32'h0, 3'd3});
        send_rx(8'h4F);
        finish_check("unexpected");

        // Abort pulse while payload byte 40 is stalled: that byte still goes out, then 'R'.
        base = tx_count;
        start_job();
        wait_tx(base + 1, "abort_hello");
        push_payload(41);
        tx_q.push_back(8'h52);
        send_rx(8'h31);
        wait_tx(base + 41, "abort_pre");
        bus.tx_ready = 1'b0;
        bus.abort    = 1'b1;
        step();
        bus.abort = 1'b0;
        step();
        check("abort_hold", {bus.tx_valid, bus.tx_data}, {1'b1, 8'hA8});
        bus.tx_ready = 1'b1;
        wait_tx(base + 43, "abort_reset");
        res_q.push_back('{1'b0, 32'h0, 3'd4});
        send_rx(8'h4F);
        finish_check("abort");

        // Reset mid-payload discards the job without sending 'R'.
        base = tx_count;
        start_job();
        wait_tx(base + 1, "rst_hello");
        push_payload(84);
        send_rx(8'h31);
        wait_tx(base + 41, "rst_pre");
        rstn = 1'b0;
        #1;
        check("rst_async_tx_valid", bus.tx_valid, 0);
        check("rst_async_ready", bus.job_ready, 1);
        tx_q.delete();
        step();
        step();
        rstn = 1'b1;
        step();
        send_rx(8'h31);
        step();
        check("idle_rx_ignored", {bus.job_ready, bus.tx_valid}, {1'b1, 1'b0});

        run_notfound("after_reset");

        repeat (5) step();
        check("tx_queue_empty", tx_q.size(), 0);
        check("res_queue_empty", res_q.size(), 0);
        check("res_total", res_count, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
